// File: rtl/processor.sv
// processor: small SIMD processor that fetches from a 16-word instruction ROM,
// executes one instruction per cycle on a 16 x 128-bit register file (four
// 32-bit lanes), and accesses a 64 x 32-bit data memory.
//
// Build option: SIMD_VECTOR_MEM_EN enables 4-cycle VLD/VST. Without it,
// VLD/VST execute as 1-cycle NOPs and offset_wire is tied to 0.
//
// Ports:
//   clk                 - clock, all state updates on rising edge
//   reset               - asynchronous active-low reset
//   instruction         - ROM[PC]
//   result              - value written back to the register file this cycle, 0 if none
//   offset_wire         - current vector lane counter (CVL)
//   reg_read_data1_wire - R[rd]
//   reg_read_data2_wire - R[rs]
//   reg_write_data_wire - value R[rd] takes at the next edge (R[rd] if no write)
//   mem_write_data_wire - data word written to memory this cycle, 0 if none
//
// ROM_IMAGE packs the 16 ROM words, word 0 in bits [31:0].
module processor #(
  parameter logic [511:0] ROM_IMAGE = {320'h0,
                                       32'hC000_0400,   // LD  r0,[1]
                                       32'hE000_0400,   // VLD r0,[1]
                                       32'hF000_0400,   // VST [1],r0
                                       32'h1404_0000,   // ADD r0,r1
                                       32'hE040_0000,   // VLD r1,[0]
                                       32'hE000_0400}   // VLD r0,[1]
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  instruction,
  output logic [127:0] result,
  output logic [1:0]   offset_wire,
  output logic [127:0] reg_read_data1_wire,
  output logic [127:0] reg_read_data2_wire,
  output logic [127:0] reg_write_data_wire,
  output logic [31:0]  mem_write_data_wire
);

  typedef enum logic [1:0] {
    T_REG = 2'b00,
    T_IMM = 2'b01,
    T_NOP = 2'b10,
    T_MEM = 2'b11
  } itype_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0101,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101
  } alu_op_e;

  typedef enum logic [3:0] {
    M_LD  = 4'b0000,
    M_ST  = 4'b0100,
    M_VLD = 4'b1000,
    M_VST = 4'b1100
  } mem_op_e;

  logic [3:0]   pc_q, pc_d;
  logic [1:0]   cvl_q, cvl_d;
  logic [127:0] regs_q [16];
  logic [31:0]  mem_q  [64];

  itype_e       itype;
  logic [3:0]   op, rd, rs;
  logic [7:0]   imm8;
  logic [127:0] opa, opb, alu_out;
  logic         alu_ok;
  logic [5:0]   maddr;
  logic [6:0]   lane_lsb;
  logic         is_nop, is_vec;
  logic         reg_we, mem_we;
  logic [127:0] reg_wdata;
  logic [31:0]  mem_wdata;

  assign instruction = ROM_IMAGE[{pc_q, 5'd0} +: 32];
  assign itype       = itype_e'(instruction[31:30]);
  assign op          = instruction[29:26];
  assign rd          = instruction[25:22];
  assign rs          = instruction[21:18];
  assign imm8        = instruction[17:10];
  assign is_nop      = (instruction == '0);

  assign opa = regs_q[rd];
  assign opb = (itype == T_IMM) ? {4{{24'd0, imm8}}} : regs_q[rs];

  // Lane address and lane bit offset both follow CVL (0 for scalar accesses).
  assign maddr    = imm8[5:0] + {4'd0, cvl_q};
  assign lane_lsb = {cvl_q, 5'd0};

`ifdef SIMD_VECTOR_MEM_EN
  assign is_vec      = (itype == T_MEM) && ((op == M_VLD) || (op == M_VST));
  assign offset_wire = cvl_q;
`else
  assign is_vec      = 1'b0;
  assign offset_wire = 2'b00;
`endif

  always_comb begin
    alu_ok  = 1'b1;
    alu_out = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      case (op)
        OP_ADD:  alu_out[l*32 +: 32] = opa[l*32 +: 32] + opb[l*32 +: 32];
        OP_SUB:  alu_out[l*32 +: 32] = opa[l*32 +: 32] - opb[l*32 +: 32];
        OP_AND:  alu_out[l*32 +: 32] = opa[l*32 +: 32] & opb[l*32 +: 32];
        OP_ORR:  alu_out[l*32 +: 32] = opa[l*32 +: 32] | opb[l*32 +: 32];
        OP_EOR:  alu_out[l*32 +: 32] = opa[l*32 +: 32] ^ opb[l*32 +: 32];
        OP_MOV:  alu_out[l*32 +: 32] = opb[l*32 +: 32];
        default: alu_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    reg_we    = 1'b0;
    reg_wdata = opa;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (itype)
      T_REG, T_IMM: begin
        if (!is_nop && alu_ok) begin
          reg_we    = 1'b1;
          reg_wdata = alu_out;
        end
      end
      T_MEM: begin
        case (op)
          M_LD: begin
            reg_we    = 1'b1;
            reg_wdata = {96'd0, mem_q[maddr]};
          end
          M_ST: begin
            mem_we    = 1'b1;
            mem_wdata = opa[31:0];
          end
          M_VLD: begin
            if (is_vec) begin
              reg_we                  = 1'b1;
              reg_wdata[lane_lsb +: 32] = mem_q[maddr];
            end
          end
          M_VST: begin
            if (is_vec) begin
              mem_we    = 1'b1;
              mem_wdata = opa[lane_lsb +: 32];
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Vector ops hold PC until the last lane; CVL wraps 3 -> 0 on its own.
  always_comb begin
    pc_d  = pc_q + 4'd1;
    cvl_d = '0;
    if (is_vec) begin
      cvl_d = cvl_q + 2'd1;
      if (cvl_q != 2'd3) pc_d = pc_q;
    end
  end

  assign reg_read_data1_wire = opa;
  assign reg_read_data2_wire = regs_q[rs];
  assign reg_write_data_wire = reg_wdata;
  // Gated by reset so nothing looks like a write while reset is held.
  assign result              = (reset && reg_we) ? reg_wdata : '0;
  assign mem_write_data_wire = (reset && mem_we) ? mem_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      cvl_q <= '0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i[3:0]] <= '0;
      for (int unsigned i = 0; i < 64; i++) mem_q[i[5:0]] <= i;
    end else begin
      pc_q  <= pc_d;
      cvl_q <= cvl_d;
      if (reg_we) regs_q[rd] <= reg_wdata;
      if (mem_we) mem_q[maddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_processor.sv
// tb_processor: scoreboard bench for processor. The driver pushes expected
// output values for each cycle into a queue; a monitor pops and compares them
// on the falling clock edge. Instance u_a runs the default program, u_b runs
// an immediate/ALU/scalar-memory program supplied through ROM_IMAGE.
`timescale 1ns/1ps
module tb_processor;

  localparam int SA_INSTR = 0, SA_OFF = 1, SA_RES = 2, SA_WD = 3, SA_MWD = 4, SA_RD1 = 5, SA_RD2 = 6;
  localparam int SB_INSTR = 8, SB_OFF = 9, SB_RES = 10, SB_WD = 11, SB_MWD = 12, SB_RD1 = 13, SB_RD2 = 14;

  localparam logic [511:0] PROG_B = {224'h0,
                                     32'h7502_0000,   // MOV r4,#0x80
                                     32'h80C0_0000,   // type-10 NOP, rd=3
                                     32'hC0C0_1400,   // LD  r3,[5]
                                     32'hD040_1400,   // ST  [5],r1
                                     32'h3C84_0000,   // undefined ALU op
                                     32'h8080_0000,   // type-10 NOP, rd=2
                                     32'h0884_0000,   // SUB r2,r1
                                     32'h5443_FC00,   // ADD r1,#255
                                     32'h5443_FC00};  // ADD r1,#255

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic [31:0]  instr_a, mwd_a, instr_b, mwd_b;
  logic [127:0] res_a, rd1_a, rd2_a, wd_a, res_b, rd1_b, rd2_b, wd_b;
  logic [1:0]   off_a, off_b;

  processor u_a (
    .clk(clk), .reset(rst_a), .instruction(instr_a), .result(res_a),
    .offset_wire(off_a), .reg_read_data1_wire(rd1_a), .reg_read_data2_wire(rd2_a),
    .reg_write_data_wire(wd_a), .mem_write_data_wire(mwd_a)
  );

  processor #(.ROM_IMAGE(PROG_B)) u_b (
    .clk(clk), .reset(rst_b), .instruction(instr_b), .result(res_b),
    .offset_wire(off_b), .reg_read_data1_wire(rd1_b), .reg_read_data2_wire(rd2_b),
    .reg_write_data_wire(wd_b), .mem_write_data_wire(mwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    int           sel;
    logic [127:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [127:0] l4(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] actual(input int sel);
    case (sel)
      SA_INSTR: return 128'(instr_a);
      SA_OFF:   return 128'(off_a);
      SA_RES:   return res_a;
      SA_WD:    return wd_a;
      SA_MWD:   return 128'(mwd_a);
      SA_RD1:   return rd1_a;
      SA_RD2:   return rd2_a;
      SB_INSTR: return 128'(instr_b);
      SB_OFF:   return 128'(off_b);
      SB_RES:   return res_b;
      SB_WD:    return wd_b;
      SB_MWD:   return 128'(mwd_b);
      SB_RD1:   return rd1_b;
      SB_RD2:   return rd2_b;
      default:  return 'x;
    endcase
  endfunction

  task automatic chk(input string tag, input int sel, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare everything queued for the current cycle.
  initial begin
    exp_t         e;
    logic [127:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = actual(e.sel);
        n_checks++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.tag, act, e.val);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [127:0] v [4];
    #1;
    chk("rst instr", SA_INSTR, 32'hE000_0400);
    chk("rst off", SA_OFF, '0);
    chk("rst result", SA_RES, '0);
    chk("rst mwd", SA_MWD, '0);
    chk("rst R0", SA_RD1, '0);
    chk("rstB instr", SB_INSTR, 32'h5443_FC00);
    chk("rstB result", SB_RES, '0);
    chk("rstB mwd", SB_MWD, '0);
    @(posedge clk);
    #1 rst_a = 1'b1;

`ifdef SIMD_VECTOR_MEM_EN
    v = '{l4(0, 0, 0, 1), l4(0, 0, 2, 1), l4(0, 3, 2, 1), l4(4, 3, 2, 1)};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      chk($sformatf("vld r0 c%0d instr", k), SA_INSTR, 32'hE000_0400);
      chk($sformatf("vld r0 c%0d off", k), SA_OFF, 128'(k));
      chk($sformatf("vld r0 c%0d wdata", k), SA_WD, v[k]);
    end
    step();
    chk("pc1 instr", SA_INSTR, 32'hE040_0000);
    chk("R0 after vld", SA_RD2, l4(4, 3, 2, 1));
    v = '{l4(0, 0, 0, 0), l4(0, 0, 1, 0), l4(0, 2, 1, 0), l4(3, 2, 1, 0)};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      chk($sformatf("vld r1 c%0d off", k), SA_OFF, 128'(k));
      chk($sformatf("vld r1 c%0d wdata", k), SA_WD, v[k]);
    end
    step();
    chk("add instr", SA_INSTR, 32'h1404_0000);
    chk("add off", SA_OFF, '0);
    chk("add R1", SA_RD2, l4(3, 2, 1, 0));
    chk("add R0", SA_RD1, l4(4, 3, 2, 1));
    chk("add result", SA_RES, l4(7, 5, 3, 1));
    chk("add wdata", SA_WD, l4(7, 5, 3, 1));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("vst c%0d instr", k), SA_INSTR, 32'hF000_0400);
      chk($sformatf("vst c%0d off", k), SA_OFF, 128'(k));
      chk($sformatf("vst c%0d mwd", k), SA_MWD, 128'(2 * k + 1));
      chk($sformatf("vst c%0d result", k), SA_RES, '0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("reload c%0d off", k), SA_OFF, 128'(k));
      chk($sformatf("reload c%0d result", k), SA_RES, l4(7, 5, 3, 1));
    end
    step();
    chk("ld instr", SA_INSTR, 32'hC000_0400);
    chk("ld R0 before", SA_RD1, l4(7, 5, 3, 1));
    chk("ld result", SA_RES, l4(0, 0, 0, 1));
`else
    chk("c0 instr", SA_INSTR, 32'hE000_0400);
    chk("c0 off", SA_OFF, '0);
    chk("c0 result", SA_RES, '0);
    chk("c0 wdata", SA_WD, '0);
    step();
    chk("c1 instr", SA_INSTR, 32'hE040_0000);
    chk("c1 off", SA_OFF, '0);
    chk("c1 result", SA_RES, '0);
    step();
    chk("add instr", SA_INSTR, 32'h1404_0000);
    chk("add result", SA_RES, '0);
    step();
    chk("vst instr", SA_INSTR, 32'hF000_0400);
    chk("vst mwd", SA_MWD, '0);
    chk("vst off", SA_OFF, '0);
    step();
    chk("vld instr", SA_INSTR, 32'hE000_0400);
    chk("vld result", SA_RES, '0);
    step();
    chk("ld instr", SA_INSTR, 32'hC000_0400);
    chk("ld result", SA_RES, l4(0, 0, 0, 1));
`endif

    for (int p = 6; p < 16; p++) begin
      step();
      chk($sformatf("nop pc%0d instr", p), SA_INSTR, '0);
      chk($sformatf("nop pc%0d result", p), SA_RES, '0);
      chk($sformatf("nop pc%0d mwd", p), SA_MWD, '0);
      chk($sformatf("nop pc%0d off", p), SA_OFF, '0);
      chk($sformatf("nop pc%0d wdata", p), SA_WD, l4(0, 0, 0, 1));
    end
    step();
    chk("wrap instr", SA_INSTR, 32'hE000_0400);
    chk("wrap R0", SA_RD1, l4(0, 0, 0, 1));
    chk("wrap off", SA_OFF, '0);

`ifdef SIMD_VECTOR_MEM_EN
    step();
    step();
    chk("pre-reset off", SA_OFF, 128'(2));
`endif

    @(negedge clk);
    #1 rst_a = 1'b0;
    #1;
    chk("midrst off", SA_OFF, '0);
    chk("midrst instr", SA_INSTR, 32'hE000_0400);
    chk("midrst R0", SA_RD1, '0);
    chk("midrst result", SA_RES, '0);
    chk("midrst mwd", SA_MWD, '0);
    @(posedge clk);
    #1 rst_a = 1'b1;

`ifdef SIMD_VECTOR_MEM_EN
    v = '{l4(0, 0, 0, 1), l4(0, 0, 2, 1), l4(0, 3, 2, 1), l4(4, 3, 2, 1)};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      chk($sformatf("post-rst vld c%0d off", k), SA_OFF, 128'(k));
      chk($sformatf("post-rst vld c%0d wdata", k), SA_WD, v[k]);
    end
`else
    chk("post-rst instr", SA_INSTR, 32'hE000_0400);
    chk("post-rst R0", SA_RD1, '0);
    for (int k = 0; k < 5; k++) step();
    chk("post-rst ld result", SA_RES, l4(0, 0, 0, 1));
`endif

    @(posedge clk);
    #1 rst_b = 1'b1;
    chk("B addi1 instr", SB_INSTR, 32'h5443_FC00);
    chk("B addi1 R1", SB_RD1, '0);
    chk("B addi1 result", SB_RES, l4(255, 255, 255, 255));
    step();
    chk("B addi2 R1", SB_RD1, l4(255, 255, 255, 255));
    chk("B addi2 result", SB_RES, l4(510, 510, 510, 510));
    step();
    chk("B sub instr", SB_INSTR, 32'h0884_0000);
    chk("B sub R2", SB_RD1, '0);
    chk("B sub R1", SB_RD2, l4(510, 510, 510, 510));
    chk("B sub result", SB_RES, l4(32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02));
    chk("B sub wdata", SB_WD, l4(32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02));
    step();
    chk("B nop10 R2", SB_RD1, l4(32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02));
    chk("B nop10 result", SB_RES, '0);
    chk("B nop10 wdata", SB_WD, l4(32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02));
    step();
    chk("B badop result", SB_RES, '0);
    chk("B badop wdata", SB_WD, l4(32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02, 32'hFFFF_FE02));
    chk("B badop mwd", SB_MWD, '0);
    step();
    chk("B st mwd", SB_MWD, 128'(510));
    chk("B st result", SB_RES, '0);
    step();
    chk("B ld result", SB_RES, l4(0, 0, 0, 510));
    step();
    chk("B R3", SB_RD1, l4(0, 0, 0, 510));
    chk("B nop result", SB_RES, '0);
    step();
    chk("B movi result", SB_RES, l4(32'h80, 32'h80, 32'h80, 32'h80));
    chk("B off", SB_OFF, '0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
